colour_centroid_tracker: RTL and testbench

Parametrised multi-class colour centroid tracker on the camera Avalon-ST video path, between the camera frame source and the VGA sink. Each accepted pixel is classified against NUM_CLASSES runtime-programmable RGB box thresholds. Per-class pixel count and x/y coordinate sums accumulate over each frame. At end of frame a shared sequential divider produces per-class centroids, presence and centre-window flags. Video passes through on a one-stage registered pipeline with true backpressure and an optional overlay that marks matched pixels.

---
 rtl/colour_centroid_tracker_pkg.sv | 35 +++
 rtl/colour_centroid_tracker_if.sv | 15 +
 rtl/colour_centroid_tracker_seq_divider.sv | 61 ++++++
 rtl/colour_centroid_tracker.sv | 223 ++++++++++++++++++++++
 tb/tb_colour_centroid_tracker.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/colour_centroid_tracker_pkg.sv
// Shared types and width helpers for the colour centroid tracker.
// Widths are derived from the frame geometry so accumulators can never wrap.
package centroid_pkg;

    localparam int PIX_W = 30;

    typedef struct packed {
        logic [7:0] r_min;
        logic [7:0] r_max;
        logic [7:0] g_min;
        logic [7:0] g_max;
        logic [7:0] b_min;
        logic [7:0] b_max;
    } rgb_thresh_t;

    typedef enum logic [1:0] {ACCUM, LOAD, DIVIDE, PUBLISH} state_e;

    function automatic int calc_xw(input int w);
        return $clog2(w);
    endfunction

    function automatic int calc_yw(input int h);
        return $clog2(h);
    endfunction

    function automatic int calc_cw(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    // x_sum worst case is below WIDTH*WIDTH*HEIGHT, y_sum is smaller still
    function automatic int calc_sw(input int w, input int h);
        return $clog2(w * w * h);
    endfunction

endpackage

// File: rtl/colour_centroid_tracker_if.sv
// Avalon-ST video beat bundle: data, packet delimiters, valid/ready handshake.
interface colour_centroid_tracker_if
    import centroid_pkg::*;
#(
    parameter int DW = PIX_W
);
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          valid;
    logic          ready;

    modport master (output data, sop, eop, valid, input ready);
    modport slave  (input data, sop, eop, valid, output ready);
endinterface

// File: rtl/colour_centroid_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; a zero divisor yields 0.
// o_done flags the cycle whose clock edge retires the final quotient bit.
module seq_divider #(
    parameter int DVD_W = 8,
    parameter int DSR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DSR_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quot
);
    localparam int NW = $clog2(DVD_W + 1);

    logic [DSR_W-1:0] r_rem;
    logic [DVD_W-1:0] r_quot;
    logic [DSR_W-1:0] r_dsr;
    logic [NW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_zero;
    logic [DSR_W:0]   w_trial;
    logic [DSR_W:0]   w_diff;
    logic             w_fit;

    // Dividend bits shift out of r_quot's top as quotient bits shift in below
    assign w_trial = {r_rem, r_quot[DVD_W-1]};
    assign w_fit   = w_trial >= {1'b0, r_dsr};
    assign w_diff  = w_trial - {1'b0, r_dsr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_zero <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_dsr  <= i_divisor;
            r_cnt  <= NW'(DVD_W);
            r_busy <= 1'b1;
            r_zero <= (i_divisor == '0);
        end else if (r_busy) begin
            r_rem  <= w_fit ? w_diff[DSR_W-1:0] : w_trial[DSR_W-1:0];
            r_quot <= {r_quot[DVD_W-2:0], w_fit};
            r_cnt  <= r_cnt - NW'(1);
            if (r_cnt == NW'(1))
                r_busy <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == NW'(1));
    assign o_quot = r_zero ? '0 : r_quot;

endmodule

// File: rtl/colour_centroid_tracker.sv
// Multi-class RGB box classifier with per-frame centroid computation and a
// one-stage registered Avalon-ST pass-through with optional match overlay.
module colour_centroid_tracker
    import centroid_pkg::*;
#(
    parameter int          WIDTH          = 320,
    parameter int          HEIGHT         = 240,
    parameter int          NUM_CLASSES    = 2,
    parameter int          MIN_PIXELS     = 16,
    parameter int          WINDOW         = 60,
    parameter logic [29:0] OVERLAY_COLOUR = 30'h3FF00000,
    localparam int         XW             = calc_xw(WIDTH),
    localparam int         YW             = calc_yw(HEIGHT),
    localparam int         CW             = calc_cw(WIDTH, HEIGHT),
    localparam int         SW             = calc_sw(WIDTH, HEIGHT)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_enable,
    input  logic                                i_overlay,
    input  logic [NUM_CLASSES*48-1:0]           i_thresholds,
    colour_centroid_tracker_if.slave            i_sink,
    colour_centroid_tracker_if.master           o_src,
    output logic                                o_centroid_valid,
    output logic [NUM_CLASSES-1:0][XW-1:0]      o_x_centroid,
    output logic [NUM_CLASSES-1:0][YW-1:0]      o_y_centroid,
    output logic [NUM_CLASSES-1:0][CW-1:0]      o_class_count,
    output logic [NUM_CLASSES-1:0]              o_class_present,
    output logic [NUM_CLASSES-1:0]              o_in_window,
    output logic                                o_frame_overrun
);
    localparam int ND     = 2 * NUM_CLASSES;
    localparam int IW     = (ND > 1) ? $clog2(ND) : 1;
    localparam int WIN_LO = WIDTH / 2 - WINDOW;
    localparam int WIN_HI = WIDTH / 2 + WINDOW;

    logic             w_accept, w_sop, w_eop, w_meas, w_snap_evt;
    logic [XW-1:0]    r_x, w_px;
    logic [YW-1:0]    r_y, w_py;
    logic             r_meas;
    logic [7:0]       w_r, w_g, w_b;
    logic [PIX_W-1:0] r_dout;
    logic             r_sop_out, r_eop_out, r_vout;

    logic [NUM_CLASSES-1:0]          w_match;
    logic [NUM_CLASSES-1:0][CW-1:0]  r_cnt, w_cnt_nxt, r_snap_cnt;
    logic [NUM_CLASSES-1:0][SW-1:0]  r_xsum, w_xsum_nxt, r_snap_x;
    logic [NUM_CLASSES-1:0][SW-1:0]  r_ysum, w_ysum_nxt, r_snap_y;

    state_e              r_state;
    logic [IW-1:0]       r_div_idx, w_cls;
    logic [ND-2:0][SW-1:0] r_q;
    logic [ND-1:0][SW-1:0] w_qfin;
    logic                w_div_start, w_div_busy, w_div_done;
    logic [SW-1:0]       w_div_dvd, w_div_quot;

    logic [NUM_CLASSES-1:0][XW-1:0] w_pub_x;
    logic [NUM_CLASSES-1:0][YW-1:0] w_pub_y;
    logic [NUM_CLASSES-1:0]         w_pub_present, w_pub_inwin;

    assign w_accept   = i_sink.valid && i_sink.ready;
    assign w_sop      = i_sink.sop;
    assign w_eop      = i_sink.eop;
    assign w_px       = w_sop ? '0 : r_x;
    assign w_py       = w_sop ? '0 : r_y;
    assign w_meas     = w_sop ? i_enable : r_meas;
    assign w_snap_evt = w_accept && w_meas && w_eop;
    assign w_r        = i_sink.data[29:22];
    assign w_g        = i_sink.data[19:12];
    assign w_b        = i_sink.data[9:2];

    // Pixel position of the beat being accepted; SOP always restarts at (0,0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_meas <= 1'b0;
        end else if (w_accept) begin
            if (w_eop) begin
                r_x    <= '0;
                r_y    <= '0;
                r_meas <= 1'b0;
            end else begin
                r_meas <= w_meas;
                if (w_px == XW'(WIDTH - 1)) begin
                    r_x <= '0;
                    r_y <= (w_py == YW'(HEIGHT - 1)) ? w_py : w_py + YW'(1);
                end else begin
                    r_x <= w_px + XW'(1);
                    r_y <= w_py;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
        rgb_thresh_t w_th;
        assign w_th = rgb_thresh_t'(i_thresholds[c*48 +: 48]);
        assign w_match[c] = (w_r >= w_th.r_min) && (w_r <= w_th.r_max) &&
                            (w_g >= w_th.g_min) && (w_g <= w_th.g_max) &&
                            (w_b >= w_th.b_min) && (w_b <= w_th.b_max);
        assign w_cnt_nxt[c]  = (w_sop ? '0 : r_cnt[c]) + CW'(w_match[c]);
        assign w_xsum_nxt[c] = (w_sop ? '0 : r_xsum[c]) + (w_match[c] ? SW'(w_px) : '0);
        assign w_ysum_nxt[c] = (w_sop ? '0 : r_ysum[c]) + (w_match[c] ? SW'(w_py) : '0);

        assign w_pub_x[c]       = w_qfin[2*c][XW-1:0];
        assign w_pub_y[c]       = w_qfin[2*c+1][YW-1:0];
        assign w_pub_present[c] = (r_snap_cnt[c] != '0) && (int'(r_snap_cnt[c]) >= MIN_PIXELS);
        assign w_pub_inwin[c]   = w_pub_present[c] && (int'(w_pub_x[c]) >= WIN_LO) &&
                                  (int'(w_pub_x[c]) <= WIN_HI);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_xsum <= '0;
            r_ysum <= '0;
        end else if (w_accept && w_meas) begin
            r_cnt  <= w_cnt_nxt;
            r_xsum <= w_xsum_nxt;
            r_ysum <= w_ysum_nxt;
        end
    end

    // Video pass-through: holds while the sink downstream stalls
    assign i_sink.ready = !r_vout || o_src.ready;
    assign o_src.data   = r_dout;
    assign o_src.sop    = r_sop_out;
    assign o_src.eop    = r_eop_out;
    assign o_src.valid  = r_vout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout    <= '0;
            r_sop_out <= 1'b0;
            r_eop_out <= 1'b0;
            r_vout    <= 1'b0;
        end else if (w_accept) begin
            r_dout    <= (i_overlay && |w_match) ? OVERLAY_COLOUR : i_sink.data;
            r_sop_out <= w_sop;
            r_eop_out <= w_eop;
            r_vout    <= 1'b1;
        end else if (o_src.ready) begin
            r_vout <= 1'b0;
        end
    end

    // Division order x0,y0,x1,y1...; even index divides x_sum, odd y_sum
    assign w_cls       = r_div_idx >> 1;
    assign w_div_dvd   = r_div_idx[0] ? r_snap_y[w_cls] : r_snap_x[w_cls];
    assign w_div_start = (r_state == LOAD) && !w_div_busy;

    for (genvar i = 0; i < ND - 1; i++) begin : g_qfin
        assign w_qfin[i] = r_q[i];
    end
    assign w_qfin[ND-1] = w_div_quot;

    seq_divider #(.DVD_W(SW), .DSR_W(CW)) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_dividend (w_div_dvd),
        .i_divisor  (r_snap_cnt[w_cls]),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_div_quot)
    );

    // Previous quotient is still held by the divider when the next LOAD restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ACCUM;
            r_div_idx        <= '0;
            r_snap_cnt       <= '0;
            r_snap_x         <= '0;
            r_snap_y         <= '0;
            r_q              <= '0;
            o_centroid_valid <= 1'b0;
            o_frame_overrun  <= 1'b0;
            o_x_centroid     <= '0;
            o_y_centroid     <= '0;
            o_class_count    <= '0;
            o_class_present  <= '0;
            o_in_window      <= '0;
        end else begin
            o_centroid_valid <= 1'b0;
            o_frame_overrun  <= w_snap_evt && (r_state != ACCUM);
            case (r_state)
                ACCUM: if (w_snap_evt) begin
                    r_snap_cnt <= w_cnt_nxt;
                    r_snap_x   <= w_xsum_nxt;
                    r_snap_y   <= w_ysum_nxt;
                    r_div_idx  <= '0;
                    r_state    <= LOAD;
                end
                LOAD: begin
                    if (r_div_idx != '0)
                        r_q[r_div_idx - IW'(1)] <= w_div_quot;
                    r_state <= DIVIDE;
                end
                DIVIDE: if (w_div_done) begin
                    if (r_div_idx == IW'(ND - 1)) begin
                        r_state <= PUBLISH;
                    end else begin
                        r_div_idx <= r_div_idx + IW'(1);
                        r_state   <= LOAD;
                    end
                end
                PUBLISH: begin
                    o_x_centroid     <= w_pub_x;
                    o_y_centroid     <= w_pub_y;
                    o_class_count    <= r_snap_cnt;
                    o_class_present  <= w_pub_present;
                    o_in_window      <= w_pub_inwin;
                    o_centroid_valid <= 1'b1;
                    r_state          <= ACCUM;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_colour_centroid_tracker.sv
// Directed bench for colour_centroid_tracker on an 8x4 frame with red and green classes.
module tb_colour_centroid_tracker;
    localparam int W = 8, H = 4, N = 2, XW = 3, YW = 2, CW = 6, LAT = 37;
    localparam logic [29:0] OVL = 30'h3FF00000;
    localparam logic [29:0] RED = {8'd200, 2'b00, 8'd10, 2'b00, 8'd10, 2'b00};
    localparam logic [29:0] GRN = {8'd10, 2'b00, 8'd200, 2'b00, 8'd10, 2'b00};

    typedef struct {
        int rx0, rx1, ry0, ry1;
        int gx0, gx1, gy0, gy1;
        int cnt0, x0, y0, p0, w0;
        int cnt1, x1, y1, p1, w1;
    } frame_vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic i_enable, i_overlay;
    logic [N*48-1:0] i_thresholds;
    logic o_centroid_valid, o_frame_overrun;
    logic [N-1:0][XW-1:0] o_x_centroid;
    logic [N-1:0][YW-1:0] o_y_centroid;
    logic [N-1:0][CW-1:0] o_class_count;
    logic [N-1:0] o_class_present, o_in_window;

    colour_centroid_tracker_if sink_if ();
    colour_centroid_tracker_if src_if ();

    colour_centroid_tracker #(
        .WIDTH(W), .HEIGHT(H), .NUM_CLASSES(N), .MIN_PIXELS(3), .WINDOW(1), .OVERLAY_COLOUR(OVL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_enable         (i_enable),
        .i_overlay        (i_overlay),
        .i_thresholds     (i_thresholds),
        .i_sink           (sink_if),
        .o_src            (src_if),
        .o_centroid_valid (o_centroid_valid),
        .o_x_centroid     (o_x_centroid),
        .o_y_centroid     (o_y_centroid),
        .o_class_count    (o_class_count),
        .o_class_present  (o_class_present),
        .o_in_window      (o_in_window),
        .o_frame_overrun  (o_frame_overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, cv_n = 0, cv_cyc = 0, ov_n = 0, eop_cyc = 0;
    logic [29:0] out_q[$];
    logic [29:0] exp_q[$];
    frame_vec_t vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (src_if.valid && src_if.ready) out_q.push_back(src_if.data);
        if (o_centroid_valid) begin
            cv_n   <= cv_n + 1;
            cv_cyc <= cyc;
        end
        if (o_frame_overrun) ov_n <= ov_n + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pix(input frame_vec_t v, input int x, input int y);
        if (x >= v.gx0 && x <= v.gx1 && y >= v.gy0 && y <= v.gy1) return GRN;
        if (x >= v.rx0 && x <= v.rx1 && y >= v.ry0 && y <= v.ry1) return RED;
        return '0;
    endfunction

    // Called and returns at #1 after a rising edge
    task automatic send_frame(input frame_vec_t v, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            logic [29:0] px = pix(v, i % W, i / W);
            bit acc = 0;
            int guard = 0;
            sink_if.data  = px;
            sink_if.sop   = (i == 0);
            sink_if.eop   = (i == nbeats - 1);
            sink_if.valid = 1'b1;
            while (!acc && guard < 100) begin
                @(negedge clk);
                acc = sink_if.ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) check("send_accept", 0, 1);
            exp_q.push_back((i_overlay && px != '0) ? OVL : px);
            if (i == nbeats - 1) eop_cyc = cyc;
        end
        sink_if.valid = 1'b0;
        sink_if.sop   = 1'b0;
        sink_if.eop   = 1'b0;
    endtask

    task automatic wait_cv(input int prev, input string tag);
        int g = 0;
        while (cv_n == prev && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check({tag, "_cv_seen"}, cv_n - prev, 1);
    endtask

    task automatic check_frame(input frame_vec_t v, input int e0, input string tag);
        check({tag, "_latency"}, cv_cyc - e0, LAT);
        check({tag, "_cnt0"}, o_class_count[0], v.cnt0);
        check({tag, "_x0"}, o_x_centroid[0], v.x0);
        check({tag, "_y0"}, o_y_centroid[0], v.y0);
        check({tag, "_pres0"}, o_class_present[0], v.p0);
        check({tag, "_win0"}, o_in_window[0], v.w0);
        check({tag, "_cnt1"}, o_class_count[1], v.cnt1);
        check({tag, "_x1"}, o_x_centroid[1], v.x1);
        check({tag, "_y1"}, o_y_centroid[1], v.y1);
        check({tag, "_pres1"}, o_class_present[1], v.p1);
        check({tag, "_win1"}, o_in_window[1], v.w1);
    endtask

    task automatic compare_stream(input string tag);
        int bad = 0;
        check({tag, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            if (out_q[i] !== exp_q[i]) bad++;
        check({tag, "_data_errs"}, bad, 0);
    endtask

    task automatic clear_streams();
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cv"}, o_centroid_valid, 0);
        check({tag, "_ovr"}, o_frame_overrun, 0);
        check({tag, "_x"}, o_x_centroid, 0);
        check({tag, "_y"}, o_y_centroid, 0);
        check({tag, "_cnt"}, o_class_count, 0);
        check({tag, "_pres"}, o_class_present, 0);
        check({tag, "_win"}, o_in_window, 0);
        check({tag, "_vout"}, src_if.valid, 0);
        check({tag, "_rdy"}, sink_if.ready, 1);
    endtask

    initial begin
        int prev, pov, e0;
        frame_vec_t one;
        //              red rect        green rect       c0: cnt x y p w   c1: cnt x y p w
        vecs[0] = '{2, 3, 1, 2,   1, 0, 0, 0,   4, 2, 1, 1, 0,    0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0,   1, 0, 0, 0,   0, 0, 0, 0, 0,    0, 0, 0, 0, 0};
        vecs[2] = '{4, 6, 0, 0,   0, 1, 3, 3,   3, 5, 0, 1, 1,    2, 0, 3, 0, 0};
        vecs[3] = '{0, 7, 0, 3,   7, 7, 0, 3,   28, 3, 1, 1, 1,   4, 7, 1, 1, 0};
        one     = '{0, 7, 0, 3,   1, 0, 0, 0,   0, 0, 0, 0, 0,    0, 0, 0, 0, 0};

        i_enable      = 1'b1;
        i_overlay     = 1'b0;
        i_thresholds  = {8'd0, 8'd70, 8'd120, 8'd255, 8'd0, 8'd70,
                         8'd120, 8'd255, 8'd0, 8'd70, 8'd0, 8'd70};
        sink_if.data  = '0;
        sink_if.sop   = 1'b0;
        sink_if.eop   = 1'b0;
        sink_if.valid = 1'b0;
        src_if.ready  = 1'b1;

        #2;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            clear_streams();
            prev = cv_n;
            send_frame(vecs[i], W * H);
            wait_cv(prev, $sformatf("vec%0d", i));
            check_frame(vecs[i], eop_cyc, $sformatf("vec%0d", i));
            compare_stream($sformatf("vec%0d_stream", i));
        end

        // Downstream stall mid-line
        clear_streams();
        prev = cv_n;
        fork
            send_frame(vecs[0], W * H);
            begin
                repeat (12) @(posedge clk);
                #1 src_if.ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 src_if.ready = 1'b1;
            end
        join
        wait_cv(prev, "stall");
        check_frame(vecs[0], eop_cyc, "stall");
        compare_stream("stall_stream");

        // Second measured EOP arrives 10 cycles after the first
        prev = cv_n;
        pov  = ov_n;
        send_frame(vecs[0], W * H);
        e0 = eop_cyc;
        repeat (9) @(posedge clk);
        #1;
        send_frame(one, 1);
        check("overrun_eop_gap", eop_cyc - e0, 10);
        wait_cv(prev, "overrun");
        check_frame(vecs[0], e0, "overrun");
        repeat (60) @(posedge clk);
        #1;
        check("overrun_pulses", ov_n - pov, 1);
        check("overrun_no_extra_cv", cv_n - prev, 1);

        // Unmeasured frame with overlay
        clear_streams();
        i_enable  = 1'b0;
        i_overlay = 1'b1;
        prev = cv_n;
        pov  = ov_n;
        send_frame(vecs[2], W * H);
        repeat (60) @(posedge clk);
        #1;
        check("unmeasured_no_cv", cv_n - prev, 0);
        check("unmeasured_no_ovr", ov_n - pov, 0);
        compare_stream("overlay_stream");
        check("overlay_x0_held", o_x_centroid[0], 2);
        i_enable  = 1'b1;
        i_overlay = 1'b0;

        // Reset in the middle of the second division
        prev = cv_n;
        send_frame(vecs[2], W * H);
        repeat (15) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_zero_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("midreset_no_cv", cv_n - prev, 0);
        prev = cv_n;
        send_frame(vecs[3], W * H);
        wait_cv(prev, "postreset");
        check_frame(vecs[3], eop_cyc, "postreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
